// File: rtl/ff_wen_rr_arbiter.sv
// Round-robin arbiter sharing one enable-DFF register; grant same cycle, registered write one cycle later.
// Optional burst lock via `FF_WEN_ARB_LOCK_EN` (adds req_lock input).
module ff_wen_rr_arbiter #(
   parameter int REQ_NUM  = 4,
   parameter int DATA_LEN = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        hold,
   input  logic [REQ_NUM-1:0]          req_valid,
   input  logic [REQ_NUM*DATA_LEN-1:0] req_data,
`ifdef FF_WEN_ARB_LOCK_EN
   input  logic [REQ_NUM-1:0]          req_lock,
`endif
   output logic [REQ_NUM-1:0]          req_ready,
   output logic                        ff_wen,
   output logic [DATA_LEN-1:0]         ff_data_in,
   output logic [$clog2(REQ_NUM)-1:0]  grant_id
);

   localparam int             IDW     = $clog2(REQ_NUM);
   localparam logic [IDW:0]   REQ_CNT = (IDW+1)'(REQ_NUM);
   localparam logic [IDW-1:0] LAST_ID = IDW'(REQ_NUM - 1);

   typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

   state_t              state;
   logic [IDW-1:0]      ptr;
   logic [IDW-1:0]      winner;
   logic [IDW-1:0]      ptr_nxt;
   logic [IDW:0]        idx;
   logic                found;
   logic                grant;
   logic [DATA_LEN-1:0] data_arr [REQ_NUM];

   always_comb begin
      for (int k = 0; k < REQ_NUM; k++) begin
         data_arr[k] = req_data[k*DATA_LEN +: DATA_LEN];
      end
   end

   // Scan from ptr upward with an explicit wrap, first valid requester wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int k = 0; k < REQ_NUM; k++) begin
         idx = {1'b0, ptr} + (IDW+1)'(k);
         if (idx >= REQ_CNT) begin
            idx = idx - REQ_CNT;
         end
         if (!found && req_valid[idx[IDW-1:0]]) begin
            found  = 1'b1;
            winner = idx[IDW-1:0];
         end
      end
   end

   assign grant = found & ~hold & rst_n;

   always_comb begin
      req_ready = '0;
      if (grant) begin
         req_ready[winner] = 1'b1;
      end
   end

   always_comb begin
      ptr_nxt = (winner == LAST_ID) ? '0 : winner + 1'b1;
`ifdef FF_WEN_ARB_LOCK_EN
      if (req_lock[winner]) begin
         ptr_nxt = winner;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         ptr        <= '0;
         ff_data_in <= '0;
         grant_id   <= '0;
      end else if (grant) begin
         state      <= WRITE;
         ptr        <= ptr_nxt;
         ff_data_in <= data_arr[winner];
         grant_id   <= winner;
      end else begin
         state      <= IDLE;
      end
   end

   assign ff_wen = (state == WRITE);

endmodule

// File: tb/tb_ff_wen_rr_arbiter.sv
// Randomized + directed bench for ff_wen_rr_arbiter against a queue-free behavioural model.
module tb_ff_wen_rr_arbiter;
   localparam int N  = 4;
   localparam int DL = 32;

   logic            clk;
   logic            rst_n;
   logic            hold;
   logic [N-1:0]    req_valid;
   logic [N*DL-1:0] req_data;
`ifdef FF_WEN_ARB_LOCK_EN
   logic [N-1:0]    req_lock;
`endif
   logic [N-1:0]    req_ready;
   logic            ff_wen;
   logic [DL-1:0]   ff_data_in;
   logic [1:0]      grant_id;

   int total = 0;
   int bad   = 0;

   // model state
   int            m_ptr;
   logic          m_wen;
   logic [DL-1:0] m_data;
   int            m_gid;

   ff_wen_rr_arbiter #(.REQ_NUM(N), .DATA_LEN(DL)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .hold       (hold),
      .req_valid  (req_valid),
      .req_data   (req_data),
`ifdef FF_WEN_ARB_LOCK_EN
      .req_lock   (req_lock),
`endif
      .req_ready  (req_ready),
      .ff_wen     (ff_wen),
      .ff_data_in (ff_data_in),
      .grant_id   (grant_id)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One cycle: check same-cycle grant, clock, then check registered outputs.
   task automatic step(output int dut_w);
      int  mw;
      int  i;
      logic lk;
      #1;
      mw = -1;
      if (rst_n && !hold) begin
         for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (mw < 0 && req_valid[i]) mw = i;
         end
      end
      chk("req_ready", 64'(req_ready), (mw < 0) ? 64'd0 : (64'd1 << mw));
      dut_w = -1;
      for (int k = 0; k < N; k++) if (req_ready[k]) dut_w = k;
      lk = 1'b0;
`ifdef FF_WEN_ARB_LOCK_EN
      if (mw >= 0) lk = req_lock[mw];
`endif
      @(posedge clk);
      if (!rst_n) begin
         m_ptr = 0; m_wen = 1'b0; m_data = '0; m_gid = 0;
      end else if (mw >= 0) begin
         m_wen  = 1'b1;
         m_data = req_data[mw*DL +: DL];
         m_gid  = mw;
         m_ptr  = lk ? mw : (mw + 1) % N;
      end else begin
         m_wen = 1'b0;
      end
      #1;
      chk("ff_wen", 64'(ff_wen), 64'(m_wen));
      chk("ff_data_in", 64'(ff_data_in), 64'(m_data));
      chk("grant_id", 64'(grant_id), 64'(m_gid));
   endtask

   task automatic set_data(input int r, input logic [DL-1:0] d);
      req_data[r*DL +: DL] = d;
   endtask

   initial begin
      int w;
      int rr_exp [8];
      int ws_exp [3];
      m_ptr = 0; m_wen = 1'b0; m_data = '0; m_gid = 0;
      rst_n = 1'b0; hold = 1'b0; req_valid = '0; req_data = '0;
`ifdef FF_WEN_ARB_LOCK_EN
      req_lock = '0;
`endif
      // reset then idle
      step(w); step(w);
      rst_n = 1'b1;
      step(w);
      chk("idle_wen", 64'(ff_wen), 64'd0);
      chk("idle_data", 64'(ff_data_in), 64'd0);
      chk("idle_ready", 64'(w), -64'sd1);

      // single write
      req_valid = 4'b0100; set_data(2, 32'hDEAD_BEEF);
      step(w);
      chk("single_grant", 64'(w), 64'd2);
      chk("single_data", 64'(ff_data_in), 64'hDEAD_BEEF);
      chk("single_gid", 64'(grant_id), 64'd2);
      req_valid = '0;
      step(w);
      chk("single_after", 64'(ff_wen), 64'd0);

      // round robin from reset
      rst_n = 1'b0; step(w); rst_n = 1'b1;
      rr_exp = '{0, 1, 2, 3, 0, 1, 2, 3};
      req_valid = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         for (int r = 0; r < N; r++) set_data(r, $urandom);
         step(w);
         chk("rr_seq", 64'(w), 64'(rr_exp[c]));
         chk("rr_wen", 64'(ff_wen), 64'd1);
      end

      // wrap and skip
      ws_exp = '{0, 2, 0};
      req_valid = 4'b0101;
      for (int c = 0; c < 3; c++) begin
         step(w);
         chk("wrap_skip", 64'(w), 64'(ws_exp[c]));
      end

      // hold
      hold = 1'b1; req_valid = 4'b0010;
      for (int c = 0; c < 3; c++) begin
         step(w);
         chk("hold_wen", 64'(ff_wen), 64'd0);
      end
      hold = 1'b0;
      step(w);
      chk("hold_release", 64'(w), 64'd1);

`ifdef FF_WEN_ARB_LOCK_EN
      rst_n = 1'b0; step(w); rst_n = 1'b1;
      req_valid = 4'b0011; req_lock = 4'b0001;
      for (int c = 0; c < 3; c++) begin
         step(w);
         chk("lock_burst", 64'(w), 64'd0);
      end
      req_lock = '0;
      step(w); // still grants 0 since ptr stayed at 0 after the locked grant
      step(w);
      chk("lock_release", 64'(w), 64'd1);
`endif

      // reset mid-stream
      req_valid = 4'b1111;
      step(w); step(w);
      rst_n = 1'b0;
      step(w);
      chk("mid_rst_wen", 64'(ff_wen), 64'd0);
      rst_n = 1'b1;
      step(w);
      chk("mid_rst_first", 64'(w), 64'd0);

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         req_valid = N'($urandom);
         hold      = ($urandom_range(0, 4) == 0);
         rst_n     = ($urandom_range(0, 40) != 0);
         for (int r = 0; r < N; r++) set_data(r, $urandom);
`ifdef FF_WEN_ARB_LOCK_EN
         req_lock  = N'($urandom) & N'($urandom);
`endif
         step(w);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
